// File: rtl/pipe_pkg.sv
// Shared pipeline constants and the occupancy encoding used by inter-stage registers.
package pipe_pkg;

    localparam logic [31:0] PIPE_NOP         = 32'd0;
    localparam logic [31:0] PIPE_RESET_INSTR = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccFull  = 2'd2
    } occ_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_skid_reg.sv
// Inter-stage pipeline register: valid/ready handshake, 2-entry skid buffer, flush and
// a saturating stall-cycle counter. in_ready_o comes straight from a flop.
module pipeline_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W     = 64,
    parameter logic [DATA_W-1:0] RESET_DATA = {DATA_W{1'b1}},
    parameter logic [DATA_W-1:0] FLUSH_DATA = {DATA_W{1'b0}},
    parameter int unsigned       CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    input  logic              stall_clr_i
);

    logic              main_valid_q, main_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              acc, pop;
    occ_e              occ;

    assign in_ready_o  = ~skid_valid_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;
    assign acc         = in_valid_i & in_ready_o;
    assign pop         = main_valid_q & out_ready_i;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush_i) begin
            // A same-cycle accept is dropped; a same-cycle pop already left downstream.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            main_data_d  = FLUSH_DATA;
        end else if (skid_valid_q) begin
            if (pop) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q) begin
            if (acc && pop) begin
                main_data_d = in_data_i;
            end else if (pop) begin
                main_valid_d = 1'b0;
            end else if (acc) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data_i;
            end
        end else if (acc) begin
            main_valid_d = 1'b1;
            main_data_d  = in_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid_q <= 1'b0;
            main_data_q  <= RESET_DATA;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    // Skid is only ever filled behind a valid main entry.
    always_comb begin
        occ = OccEmpty;
        unique case ({skid_valid_q, main_valid_q})
            2'b01:   occ = OccOne;
            2'b11:   occ = OccFull;
            default: occ = OccEmpty;
        endcase
    end

    assign occupancy_o = occ;

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .inc_i(main_valid_q & ~out_ready_i),
        .clr_i(stall_clr_i),
        .cnt_o(stall_cnt_o)
    );

endmodule

// File: tb/tb_pipeline_skid_reg.sv
// Directed table-driven bench for pipeline_skid_reg, plus a narrow-counter saturation run.
module tb_pipeline_skid_reg;
    import pipe_pkg::*;

    localparam int unsigned DW = 64;
    localparam logic [DW-1:0] ONES = {PIPE_RESET_INSTR, PIPE_RESET_INSTR};
    localparam logic [DW-1:0] ZERO = {PIPE_NOP, PIPE_NOP};

    logic          clk = 1'b0;
    logic          rst, flush, in_valid, out_ready, stall_clr;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt;
    logic          s_in_ready, s_out_valid;
    logic [DW-1:0] s_out_data;
    logic [1:0]    s_occupancy;
    logic [1:0]    s_stall_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_skid_reg #(
        .DATA_W(DW), .RESET_DATA(ONES), .FLUSH_DATA(ZERO), .CNT_W(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(in_ready), .in_data_i(in_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .occupancy_o(occupancy),
        .stall_cnt_o(stall_cnt), .stall_clr_i(stall_clr)
    );

    pipeline_skid_reg #(
        .DATA_W(DW), .RESET_DATA(ONES), .FLUSH_DATA(ZERO), .CNT_W(2)
    ) dut_sat (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid),
        .in_ready_o(s_in_ready), .in_data_i(in_data), .out_valid_o(s_out_valid),
        .out_ready_i(out_ready), .out_data_o(s_out_data), .occupancy_o(s_occupancy),
        .stall_cnt_o(s_stall_cnt), .stall_clr_i(stall_clr)
    );

    typedef struct {
        logic          rst;
        logic          flush;
        logic          ivld;
        logic [DW-1:0] din;
        logic          ordy;
        logic          clr;
        logic          e_ov;
        logic [DW-1:0] e_od;
        logic          e_ir;
        int            e_occ;
        int            e_sc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic f, input logic iv, input logic [DW-1:0] d,
                       input logic ordy, input logic clr, input logic ov,
                       input logic [DW-1:0] od, input logic ir, input int occ, input int sc);
        vec_t v;
        v.rst = r; v.flush = f; v.ivld = iv; v.din = d; v.ordy = ordy; v.clr = clr;
        v.e_ov = ov; v.e_od = od; v.e_ir = ir; v.e_occ = occ; v.e_sc = sc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
        in_data = '0;

        //  rst f  iv din    ordy clr | ov od     ir occ sc
        add(1, 0, 1, 'h55,  1, 0,    0, ONES,  1, 0, 0);
        add(1, 0, 1, 'h55,  1, 0,    0, ONES,  1, 0, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, 1, DW'(k), 1, 0, 1, DW'(k), 1, 1, 0);
        add(0, 0, 0, 'h99,  1, 0,    0, 'h8,   1, 0, 0);
        // Skid: A, then B into skid, C held upstream
        add(0, 0, 1, 'hA,   1, 0,    1, 'hA,   1, 1, 0);
        add(0, 0, 1, 'hB,   0, 0,    1, 'hA,   0, 2, 1);
        add(0, 0, 1, 'hC,   0, 0,    1, 'hA,   0, 2, 2);
        add(0, 0, 1, 'hC,   1, 0,    1, 'hB,   1, 1, 2);
        add(0, 0, 1, 'hC,   1, 0,    1, 'hC,   1, 1, 2);
        add(0, 0, 0, 'h0,   1, 0,    0, 'hC,   1, 0, 2);
        // Stall counter: clear, load, 5 stall cycles, clear during stall
        add(0, 0, 0, 'h0,   1, 1,    0, 'hC,   1, 0, 0);
        add(0, 0, 1, 'h10,  0, 0,    1, 'h10,  1, 1, 0);
        for (int k = 1; k <= 5; k++) add(0, 0, 0, 'h0, 0, 0, 1, 'h10, 1, 1, k);
        add(0, 0, 0, 'h0,   0, 1,    1, 'h10,  1, 1, 0);
        add(0, 0, 0, 'h0,   0, 0,    1, 'h10,  1, 1, 1);
        // Flush while full and offering 0xD
        add(0, 0, 1, 'h20,  0, 0,    1, 'h10,  0, 2, 2);
        add(0, 1, 1, 'hD,   0, 0,    0, ZERO,  1, 0, 3);
        add(0, 0, 0, 'hD,   1, 0,    0, ZERO,  1, 0, 3);
        // Flush with a real same-cycle accept and pop
        add(0, 0, 1, 'h31,  1, 0,    1, 'h31,  1, 1, 3);
        add(0, 1, 1, 'hE,   1, 0,    0, ZERO,  1, 0, 3);
        add(0, 0, 0, 'hE,   1, 0,    0, ZERO,  1, 0, 3);
        // Reset beats flush mid-operation
        add(0, 0, 1, 'h40,  0, 0,    1, 'h40,  1, 1, 3);
        add(0, 0, 1, 'h41,  0, 0,    1, 'h40,  0, 2, 4);
        add(1, 1, 1, 'h42,  0, 0,    0, ONES,  1, 0, 0);
        add(0, 0, 0, 'h0,   1, 0,    0, ONES,  1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            int   e_sat;
            v = vecs[i];
            rst = v.rst; flush = v.flush; in_valid = v.ivld; in_data = v.din;
            out_ready = v.ordy; stall_clr = v.clr;
            step();
            e_sat = (v.e_sc > 3) ? 3 : v.e_sc;
            check($sformatf("v%0d out_valid", i), DW'(out_valid), DW'(v.e_ov));
            check($sformatf("v%0d out_data", i), out_data, v.e_od);
            check($sformatf("v%0d in_ready", i), DW'(in_ready), DW'(v.e_ir));
            check($sformatf("v%0d occupancy", i), DW'(occupancy), DW'(v.e_occ));
            check($sformatf("v%0d stall_cnt", i), DW'(stall_cnt), DW'(v.e_sc));
            check($sformatf("v%0d sat_stall_cnt", i), DW'(s_stall_cnt), DW'(e_sat));
        end

        // 6-cycle stall on the 2-bit counter instance
        rst = 1'b0; flush = 1'b0; stall_clr = 1'b0;
        in_valid = 1'b1; in_data = 'h50; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        check("sat6 sat_stall_cnt", DW'(s_stall_cnt), DW'(3));
        check("sat6 stall_cnt", DW'(stall_cnt), DW'(6));
        check("sat6 out_data_stable", s_out_data, 'h50);
        check("sat6 out_valid", DW'(s_out_valid), DW'(1));
        stall_clr = 1'b1;
        step();
        check("satclr sat_stall_cnt", DW'(s_stall_cnt), DW'(0));
        check("satclr stall_cnt", DW'(stall_cnt), DW'(0));
        stall_clr = 1'b0; out_ready = 1'b1;
        step();
        check("drain occupancy", DW'(s_occupancy), DW'(0));
        check("drain in_ready", DW'(s_in_ready), DW'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
